quad_encoder_gen: RTL and testbench

- Synthetic quadrature encoder source, the driving end of the quad decoders.
- Accepts signed step commands from a host strobe and emits the matching Gray-coded A/B pair at a programmable step rate.
- Used on the bench and in hardware-in-loop setups to feed the counter inputs with a known motion profile.
- Exposes a wrapping position count so a checker can compare it against the decoder count.

---
 rtl/quad_encoder_gen_pkg.sv | 36 +++
 rtl/quad_encoder_gen_if.sv | 17 +
 rtl/quad_encoder_gen_step_timer.sv | 28 ++
 rtl/quad_encoder_gen.sv | 121 ++++++++++++
 tb/tb_quad_encoder_gen.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared constants for the quadrature source: Gray sequence, FSM states, saturation limits.
`timescale 1ns/1ps
package quad_encoder_gen_pkg;

  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;
  localparam logic [1:0] Q_11 = 2'b11;
  localparam logic [1:0] Q_10 = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Signed saturation bounds for a w-bit two's-complement accumulator.
  function automatic int sat_max(int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned w);
    return -(1 << (w - 1));
  endfunction

  // One Gray step forward (00->01->11->10) or backward.
  function automatic logic [1:0] gray_step(logic [1:0] q, logic fwd);
    logic [1:0] r;
    case (q)
      Q_00:    r = fwd ? Q_01 : Q_10;
      Q_01:    r = fwd ? Q_11 : Q_00;
      Q_11:    r = fwd ? Q_10 : Q_01;
      default: r = fwd ? Q_00 : Q_11;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_if.sv
// Host command / encoder output bundle for quad_encoder_gen.
`timescale 1ns/1ps
interface quad_encoder_gen_if #(
  parameter int unsigned size     = 8,
  parameter int unsigned div_size = 16
);
  logic                wr;
  logic [size-1:0]     data;
  logic [div_size-1:0] period;
  logic [1:0]          q;
  logic                busy;
  logic [size-1:0]     pos;
  logic                idx;

  modport master (output wr, data, period, input q, busy, pos, idx);
  modport slave  (input wr, data, period, output q, busy, pos, idx);
endinterface

// File: rtl/quad_encoder_gen_step_timer.sv
// Step-rate timer: ticks when timer >= period-1, cleared whenever not enabled.
`timescale 1ns/1ps
module quad_encoder_gen_step_timer #(
  parameter int unsigned div_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [div_size-1:0] period,
  input  logic                enable,
  output logic                tick_c
);

  logic [div_size-1:0] timer_q;

  // >= so a period lowered below the current count fires on the next edge.
  assign tick_c = enable && (period != '0) && (timer_q >= period - div_size'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (!enable || tick_c) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + div_size'(1);
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Synthetic quadrature encoder: signed step commands in, Gray A/B pair and wrapping position out.
// Optional index output (rev counter modulo cpr) enabled by QUAD_ENCODER_GEN_INDEX_EN.
`timescale 1ns/1ps
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int unsigned size     = 8,
  parameter int unsigned div_size = 16,
  parameter int unsigned cpr      = 16
) (
  input  logic              clk,
  input  logic              rst,
  quad_encoder_gen_if.slave bus
);

  localparam int unsigned sum_w = size + 2;
  localparam logic signed [sum_w-1:0] hi = sum_w'(sat_max(size));
  localparam logic signed [sum_w-1:0] lo = sum_w'(sat_min(size));

  if (cpr == 0) begin : g_cpr_check
    $error("cpr must be nonzero");
  end

  state_t                  state_q, state_d;
  logic                    go, run_en, tick_c, step, fwd;
  logic signed [size-1:0]  pending_q, pending_d;
  logic signed [sum_w-1:0] sum;
  logic [1:0]              q_q, q_d;
  logic [size-1:0]         pos_q, pos_d;
  logic                    busy_q;

  quad_encoder_gen_step_timer #(.div_size(div_size)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .period (bus.period),
    .enable (run_en),
    .tick_c (tick_c)
  );

  // Next state: run while there is work and a nonzero rate.
  always_comb begin
    state_d = state_q;
    go      = (pending_q != '0) && (bus.period != '0);
    case (state_q)
      ST_IDLE: if (go)  state_d = ST_RUN;
      ST_RUN:  if (!go) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    run_en = go;
  end

  // Step direction comes from pending before any same-edge write.
  always_comb begin
    fwd   = ~pending_q[size-1];
    step  = run_en && tick_c;
    sum   = sum_w'(pending_q);
    if (bus.wr) sum = sum + sum_w'($signed(bus.data));
    if (step)   sum = fwd ? sum - sum_w'(1) : sum + sum_w'(1);
    if (sum > hi)      pending_d = hi[size-1:0];
    else if (sum < lo) pending_d = lo[size-1:0];
    else               pending_d = sum[size-1:0];
    q_d   = q_q;
    pos_d = pos_q;
    if (step) begin
      q_d   = gray_step(q_q, fwd);
      pos_d = fwd ? pos_q + size'(1) : pos_q - size'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      q_q       <= Q_00;
      pos_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      q_q       <= q_d;
      pos_q     <= pos_d;
      busy_q    <= (pending_d != '0);
    end
  end

  assign bus.q    = q_q;
  assign bus.pos  = pos_q;
  assign bus.busy = busy_q;

`ifdef QUAD_ENCODER_GEN_INDEX_EN
  localparam int unsigned rev_w = (cpr > 1) ? $clog2(cpr) : 1;
  localparam logic [rev_w-1:0] rev_top = rev_w'(cpr - 1);

  logic [rev_w-1:0] rev_q, rev_d;
  logic             idx_q;

  // Revolution counter wraps at cpr in both directions.
  always_comb begin
    rev_d = rev_q;
    if (step) begin
      if (fwd) rev_d = (rev_q == rev_top) ? '0 : rev_q + rev_w'(1);
      else     rev_d = (rev_q == '0) ? rev_top : rev_q - rev_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rev_q <= '0;
      idx_q <= 1'b1;
    end else begin
      rev_q <= rev_d;
      idx_q <= (rev_d == '0) && (q_d == Q_00);
    end
  end

  assign bus.idx = idx_q;
`else
  assign bus.idx = 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: vector table, directed corner sequences, random vs model.
`timescale 1ns/1ps
module tb_quad_encoder_gen;

  localparam int unsigned SIZE = 8;
  localparam int unsigned DIV  = 16;
  localparam int          CPR  = 4;
`ifdef QUAD_ENCODER_GEN_INDEX_EN
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quad_encoder_gen_if #(.size(SIZE), .div_size(DIV)) bus ();
  quad_encoder_gen #(.size(SIZE), .div_size(DIV), .cpr(CPR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: pending count, position, Gray phase, revolution, clocks since last step.
  int m_pend, m_pos, m_qi, m_rev, m_elapsed;

  function automatic logic [1:0] gray_of(int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int clamp(int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pos = 0; m_qi = 0; m_rev = 0; m_elapsed = 0;
  endtask

  task automatic model_edge();
    int d, s;
    bit stp;
    stp = 1'b0;
    if (m_pend != 0 && bus.period != 0) begin
      m_elapsed++;
      if (m_elapsed >= int'(bus.period)) begin
        stp = 1'b1;
        m_elapsed = 0;
      end
    end else begin
      m_elapsed = 0;
    end
    s = stp ? ((m_pend > 0) ? 1 : -1) : 0;
    d = bus.wr ? int'($signed(bus.data)) : 0;
    if (stp) begin
      m_qi  = (m_qi + 4 + s) % 4;
      m_pos = (m_pos + 256 + s) % 256;
      m_rev = (m_rev + CPR + s) % CPR;
    end
    m_pend = clamp(m_pend + d - s);
  endtask

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".q"},    int'(bus.q),    int'(gray_of(m_qi)));
    check({tag, ".pos"},  int'(bus.pos),  m_pos);
    check({tag, ".busy"}, int'(bus.busy), int'(m_pend != 0));
    check({tag, ".idx"},  int'(bus.idx),  int'(IDX_EN && m_rev == 0 && m_qi == 0));
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit w, logic [7:0] d, logic [15:0] p);
    bus.wr = w; bus.data = d; bus.period = p;
  endtask

  task automatic do_reset();
    bus.wr = 1'b0; bus.data = '0;
    rst = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  data;
    logic [15:0] period;
    logic [1:0]  q;
    logic [7:0]  pos;
    bit          busy;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(bit w, logic [7:0] d, logic [15:0] p,
                              logic [1:0] q, logic [7:0] pos, bit b);
    vec_t v;
    v.wr = w; v.data = d; v.period = p; v.q = q; v.pos = pos; v.busy = b;
    return v;
  endfunction

  initial begin
    bus.wr = 1'b0; bus.data = '0; bus.period = '0;
    #1;
    do_reset();

    // Vector table: one record per clock edge, expected state after that edge.
    tbl[0]  = mk(1, 8'hFE, 2, 2'b00, 8'h00, 1);
    tbl[1]  = mk(0, 8'h00, 2, 2'b00, 8'h00, 1);
    tbl[2]  = mk(0, 8'h00, 2, 2'b10, 8'hFF, 1);
    tbl[3]  = mk(0, 8'h00, 2, 2'b10, 8'hFF, 1);
    tbl[4]  = mk(0, 8'h00, 2, 2'b11, 8'hFE, 0);
    tbl[5]  = mk(0, 8'h00, 2, 2'b11, 8'hFE, 0);
    tbl[6]  = mk(1, 8'h03, 1, 2'b11, 8'hFE, 1);
    tbl[7]  = mk(0, 8'h00, 1, 2'b10, 8'hFF, 1);
    tbl[8]  = mk(0, 8'h00, 1, 2'b00, 8'h00, 1);
    tbl[9]  = mk(0, 8'h00, 1, 2'b01, 8'h01, 0);
    tbl[10] = mk(1, 8'h00, 1, 2'b01, 8'h01, 0);
    tbl[11] = mk(1, 8'h7F, 0, 2'b01, 8'h01, 1);
    tbl[12] = mk(1, 8'h05, 0, 2'b01, 8'h01, 1);
    tbl[13] = mk(1, 8'h80, 0, 2'b01, 8'h01, 1);
    tbl[14] = mk(1, 8'h01, 0, 2'b01, 8'h01, 0);
    tbl[15] = mk(1, 8'h80, 0, 2'b01, 8'h01, 1);
    tbl[16] = mk(1, 8'h80, 0, 2'b01, 8'h01, 1);
    tbl[17] = mk(1, 8'h7F, 0, 2'b01, 8'h01, 1);
    tbl[18] = mk(0, 8'h00, 1, 2'b00, 8'h00, 0);
    tbl[19] = mk(0, 8'h00, 1, 2'b00, 8'h00, 0);
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].wr, tbl[i].data, tbl[i].period);
      step_clk();
      check($sformatf("vec%0d.q", i),    int'(bus.q),    int'(tbl[i].q));
      check($sformatf("vec%0d.pos", i),  int'(bus.pos),  int'(tbl[i].pos));
      check($sformatf("vec%0d.busy", i), int'(bus.busy), int'(tbl[i].busy));
      check($sformatf("vec%0d.idx", i),  int'(bus.idx),  int'(IDX_EN && m_rev == 0 && m_qi == 0));
    end

    // period=3, +4: q changes at N+3, N+6, N+9, N+12.
    do_reset();
    drive(1, 8'd4, 3);
    step_clk();
    drive(0, 8'd0, 3);
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      if (k == 3)  check("p3.q3",  int'(bus.q), 1);
      if (k == 6)  check("p3.q6",  int'(bus.q), 3);
      if (k == 9)  check("p3.q9",  int'(bus.q), 2);
      if (k == 11) check("p3.busy11", int'(bus.busy), 1);
      if (k == 12) begin
        check("p3.q12", int'(bus.q), 0);
        check("p3.busy12", int'(bus.busy), 0);
        check("p3.pos", int'(bus.pos), 4);
      end
    end

    // Saturation with stepping halted, then 127 single-clock steps.
    do_reset();
    drive(1, 8'd100, 0); step_clk();
    drive(1, 8'd100, 0); step_clk();
    drive(0, 8'd0, 0);   step_clk();
    check("sat.busy", int'(bus.busy), 1);
    check("sat.q",    int'(bus.q), 0);
    drive(0, 8'd0, 1);
    for (int k = 1; k <= 127; k++) begin
      step_clk();
      if (k == 126) check("sat.busy126", int'(bus.busy), 1);
    end
    check("sat.pos",     int'(bus.pos),  127);
    check("sat.qend",    int'(bus.q),    int'(gray_of(127 % 4)));
    check("sat.busyend", int'(bus.busy), 0);

    // Write landing on the same edge as the first step.
    do_reset();
    drive(1, 8'd2, 4); step_clk();
    drive(0, 8'd0, 4);
    for (int k = 0; k < 3; k++) step_clk();
    drive(1, 8'd1, 4); step_clk();
    check("same.pos1",  int'(bus.pos), 1);
    check("same.busy1", int'(bus.busy), 1);
    drive(0, 8'd0, 4);
    for (int k = 0; k < 10; k++) step_clk();
    check("same.pos",  int'(bus.pos), 3);
    check("same.busy", int'(bus.busy), 0);

    // Lowering period below the elapsed count fires on the next edge.
    do_reset();
    drive(1, 8'd3, 8); step_clk();
    drive(0, 8'd0, 8);
    for (int k = 0; k < 5; k++) step_clk();
    check("lower.pos0", int'(bus.pos), 0);
    drive(0, 8'd0, 2); step_clk();
    check("lower.pos1", int'(bus.pos), 1);
    check("lower.q1",   int'(bus.q), 1);

    // Asynchronous reset mid-run aborts everything.
    do_reset();
    drive(1, 8'd10, 2); step_clk();
    drive(0, 8'd0, 2);
    for (int k = 0; k < 6; k++) step_clk();
    check("abort.pos3", int'(bus.pos), 3);
    rst = 1'b0;
    model_reset();
    #1;
    check("abort.q",    int'(bus.q), 0);
    check("abort.pos",  int'(bus.pos), 0);
    check("abort.busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) step_clk();
    check("abort.after.pos", int'(bus.pos), 0);
    check("abort.after.q",   int'(bus.q), 0);

    // Index: high at reset and on every 4th forward step.
    do_reset();
    check("idx.reset", int'(bus.idx), int'(IDX_EN));
    drive(1, 8'd8, 1); step_clk();
    drive(0, 8'd0, 1);
    for (int k = 1; k <= 8; k++) begin
      step_clk();
      check($sformatf("idx.step%0d", k), int'(bus.idx), int'(IDX_EN && (k % 4 == 0)));
    end

    // Random commands and rates against the model.
    do_reset();
    drive(0, 8'd0, 1);
    for (int i = 0; i < 1500; i++) begin
      bus.wr   = ($urandom_range(0, 3) == 0);
      bus.data = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6) - 3);
      if ($urandom_range(0, 15) == 0) bus.period = 16'($urandom_range(0, 5));
      step_clk();
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
